// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline-stage register carrying PC, branch-delay flag and
// an opaque payload between two pipeline stages, with valid/ready handshake,
// flush-to-bubble and an optional skid entry.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   in_valid   upstream presents an instruction
//   in_ready   stage accepts input this cycle
//   in_pc      PC of incoming instruction
//   in_bd      incoming instruction is in a branch-delay slot
//   in_data    incoming payload
//   out_valid  head entry valid
//   out_ready  downstream consumes the head entry
//   out_pc     PC of head entry (or of the bubble / last drained entry)
//   out_bd     branch-delay flag of head entry (or of the bubble)
//   out_data   head payload
//   flush      discard all contents and insert a bubble
//   flush_pc   PC carried by the bubble
//   flush_bd   branch-delay flag carried by the bubble
//   occupancy  number of valid entries held (0..2)
//
// SKID=1: two entries (head + skid), in_ready registered as !skid_valid.
// SKID=0: single entry, in_ready = !out_valid | out_ready (combinational).
module pipe_stage_skid #(
  parameter int unsigned           DATA_W   = 32,
  parameter int unsigned           PC_W     = 32,
  parameter logic [PC_W-1:0]       RESET_PC = PC_W'(32'h00003000),
  parameter int unsigned           SKID     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_bd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_bd,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_pc,
  input  logic              flush_bd,
  output logic [1:0]        occupancy
);

  logic              head_valid, head_valid_n;
  logic [PC_W-1:0]   head_pc,    head_pc_n;
  logic              head_bd,    head_bd_n;
  logic [DATA_W-1:0] head_data,  head_data_n;

  logic              skid_valid, skid_valid_n;
  logic [PC_W-1:0]   skid_pc,    skid_pc_n;
  logic              skid_bd,    skid_bd_n;
  logic [DATA_W-1:0] skid_data,  skid_data_n;

  logic accept;
  logic drain;

  // With a skid entry, in_ready depends only on a register, so out_ready
  // never reaches in_ready combinationally.
  assign in_ready = (SKID != 0) ? ~skid_valid : (~head_valid | out_ready);

  assign accept = in_valid & in_ready;
  assign drain  = head_valid & out_ready;

  always_comb begin
    head_valid_n = head_valid;
    head_pc_n    = head_pc;
    head_bd_n    = head_bd;
    head_data_n  = head_data;
    skid_valid_n = skid_valid;
    skid_pc_n    = skid_pc;
    skid_bd_n    = skid_bd;
    skid_data_n  = skid_data;

    if (flush) begin
      // Bubble: invalid head, but PC/BD still visible for EPC computation.
      // A same-cycle accept is dropped here.
      head_valid_n = 1'b0;
      skid_valid_n = 1'b0;
      head_pc_n    = flush_pc;
      head_bd_n    = flush_bd;
      head_data_n  = '0;
    end else if (SKID != 0) begin
      if (drain && skid_valid) begin
        // in_ready is 0 while skid is valid, so no accept can coincide.
        head_pc_n    = skid_pc;
        head_bd_n    = skid_bd;
        head_data_n  = skid_data;
        skid_valid_n = 1'b0;
      end else if (accept && (!head_valid || drain)) begin
        head_valid_n = 1'b1;
        head_pc_n    = in_pc;
        head_bd_n    = in_bd;
        head_data_n  = in_data;
      end else if (accept) begin
        skid_valid_n = 1'b1;
        skid_pc_n    = in_pc;
        skid_bd_n    = in_bd;
        skid_data_n  = in_data;
      end else if (drain) begin
        // Payload fields hold their last values.
        head_valid_n = 1'b0;
      end
    end else begin
      if (accept) begin
        head_valid_n = 1'b1;
        head_pc_n    = in_pc;
        head_bd_n    = in_bd;
        head_data_n  = in_data;
      end else if (drain) begin
        head_valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_valid <= 1'b0;
      head_pc    <= RESET_PC;
      head_bd    <= 1'b0;
      head_data  <= '0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_bd    <= 1'b0;
      skid_data  <= '0;
    end else begin
      head_valid <= head_valid_n;
      head_pc    <= head_pc_n;
      head_bd    <= head_bd_n;
      head_data  <= head_data_n;
      skid_valid <= skid_valid_n;
      skid_pc    <= skid_pc_n;
      skid_bd    <= skid_bd_n;
      skid_data  <= skid_data_n;
    end
  end

  assign out_valid = head_valid;
  assign out_pc    = head_pc;
  assign out_bd    = head_bd;
  assign out_data  = head_data;
  assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register for the PC and per-stage payload between any two stages (F/D, D/E, E/M, M/W).
- Successor to the fixed 32-bit, always-load PC latch. Adds valid/ready handshaking for stall back-pressure, a flush that inserts a bubble, and an optional skid entry that keeps `in_ready` registered.
- The bubble carries a caller-supplied PC and branch-delay flag, so CP0 computes the correct EPC when an interrupt lands on a bubble.

Parameters:
- `DATA_W`, default 32: width of the opaque payload (instruction word, control bits, etc.).
- `PC_W`, default 32: PC width.
- `RESET_PC`, default 32'h00003000: `out_pc` value after reset.
- `SKID`, default 1: 1 gives a two-entry elastic stage with registered `in_ready`; 0 gives a single-entry stage with combinational `in_ready`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage accepts input this cycle.
- `in_pc`  in  PC_W  PC of the incoming instruction.
- `in_bd`  in  1  incoming instruction sits in a branch-delay slot.
- `in_data`  in  DATA_W  incoming payload.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  downstream consumes the head entry.
- `out_pc`  out  PC_W  PC of the head entry, or of the bubble.
- `out_bd`  out  1  branch-delay flag of the head entry, or of the bubble.
- `out_data`  out  DATA_W  head payload.
- `flush`  in  1  discard all contents and insert a bubble.
- `flush_pc`  in  PC_W  PC the bubble carries.
- `flush_bd`  in  1  branch-delay flag the bubble carries.
- `occupancy`  out  2  number of valid entries held (0..2; at most 1 when SKID=0).

Behaviour:
- **Clocking:** all state updates on the rising edge of `clk`; no asynchronous paths.
- **Reset** (`reset`==0 at the edge) has priority over every other input:
  - `out_valid`=0, skid entry invalid, `occupancy`=0.
  - `out_pc`=RESET_PC, `out_bd`=0, `out_data`=0.
  - `in_ready`=1 from the following cycle.
- **Handshake definitions:**
  - Accept = `in_valid` & `in_ready`.
  - Drain = `out_valid` & `out_ready`.
  - Latency from accept to `out_valid`: 1 cycle when the stage is empty or draining.
- **Stability under stall:** outputs hold stable while `out_valid`=1 and `out_ready`=0. The upstream may drop `in_valid` at any time; the stage never depends on upstream holding data.
- **SKID=1 (two registers: head, skid):**
  - `in_ready` = !skid_valid, registered (no combinational path from `out_ready`).
  - Accept with head empty, or head draining while skid empty → input loads into head.
  - Accept with head full, not draining → input loads into skid.
  - Drain with skid valid → skid moves to head, skid cleared; a concurrent accept is impossible because `in_ready` is 0.
  - Drain with skid empty and no accept → `out_valid` falls to 0; `out_pc`/`out_bd`/`out_data` hold their last values.
- **SKID=0:** `in_ready` = !`out_valid` | `out_ready` (combinational). An accept loads the head; a drain without accept clears `out_valid`.
- **Flush** (`reset`==1, `flush`==1):
  - `out_valid`=0 and skid invalid next cycle.
  - `out_pc`<=`flush_pc`, `out_bd`<=`flush_bd`, `out_data`<=0.
  - Any accept in the same cycle is discarded, even though `in_ready` may read 1.
  - Flush overrides stall and drain; `occupancy`=0 next cycle.
- **Occupancy:** `occupancy` = head_valid + skid_valid, registered.
- **Widths:** PC and data are carried unmodified; no arithmetic is performed on them.

Test Plan:
1. Reset then stream: `reset`=0 for 2 cycles, then PCs 0x3000, 0x3004, 0x3008 on consecutive cycles with `out_ready`=1 → each appears on `out_pc` exactly 1 cycle after accept; `occupancy`=1 throughout; `out_pc` = 0x00003000 during reset.
2. Back-pressure with SKID=1: hold `out_ready`=0 while offering 0x3000 then 0x3004 → `occupancy` goes 1, then 2; `in_ready`=0 from the cycle after the second accept; 0x3008 is held off. Release `out_ready` → outputs 0x3000 then 0x3004 in order, nothing dropped, nothing duplicated.
3. Flush under full stall: `occupancy`=2, then `flush`=1 with `flush_pc`=0x3010, `flush_bd`=1, and `in_valid`=1 on 0x3014 → next cycle `out_valid`=0, `out_pc`=0x3010, `out_bd`=1, `occupancy`=0; 0x3014 never appears.
4. SKID=0 build: `out_ready`=0 with head full → `in_ready`=0 in the same cycle; toggling `out_ready`=1 raises `in_ready` combinationally and the accept replaces the head.
5. Reset mid-stall: `occupancy`=2, then `reset`=0 while `flush`=1 and `in_valid`=1 → all outputs return to their reset values (`out_pc`=RESET_PC); `flush_pc` is ignored.
6. Width sweep: DATA_W=64, PC_W=30, random valid/ready for 10k cycles against a FIFO scoreboard → the output sequence equals the accepted sequence minus flushed entries, and `occupancy` never exceeds 2.
